// File: rtl/mario_pkg.sv
// Shared types and screen geometry for the player-sprite datapath.
// Latency: n/a (package). Backpressure: n/a.
// Holds the frame-sequencer state encoding and the 160x120 screen / 4x4 sprite constants.
package mario_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        WAIT   = 3'd1,
        ERASE  = 3'd2,
        UPDATE = 3'd3,
        DRAW   = 3'd4
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 4;
    localparam int SPRITE_H = 4;

endpackage

// File: rtl/sprite_pixel_walker.sv
// Walks the 4x4 sprite footprint one pixel per cycle and emits registered VGA writes.
// Latency: first pixel one cycle after start, then 16 consecutive plot cycles; done marks the last.
// Backpressure: none, the VGA port always accepts a write.
module sprite_pixel_walker
    import mario_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [2:0] colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] pix_colour,
    output logic       plot,
    output logic       done
);

    localparam logic [3:0] LAST_IDX = 4'(SPRITE_W * SPRITE_H - 1);

    logic [3:0] idx;
    logic       active;

    // idx holds the index of the pixel to be emitted on the next cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx        <= 4'd0;
            active     <= 1'b0;
            x          <= 8'd0;
            y          <= 7'd0;
            pix_colour <= 3'd0;
            plot       <= 1'b0;
            done       <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            if (start) begin
                x          <= base_x;
                y          <= base_y;
                pix_colour <= colour;
                plot       <= 1'b1;
                idx        <= 4'd1;
                active     <= 1'b1;
            end else if (active) begin
                x    <= base_x + {6'd0, idx[1:0]};
                y    <= base_y + {5'd0, idx[3:2]};
                plot <= 1'b1;
                idx  <= idx + 4'd1;
                if (idx == LAST_IDX) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_frame_sequencer.sv
// Per-frame erase / update / redraw sequencer for the player sprite on the 160x120 VGA port.
// Latency: each frame tick yields 16 erase cycles, 1 update cycle, 16 draw cycles (33 busy cycles).
// Backpressure: ticks landing while busy collapse into a single pending pass run right after DRAW.
module sprite_frame_sequencer
    import mario_pkg::*;
#(
    parameter int         FRAME_CYCLES  = 833333,
    parameter logic [7:0] SPAWN_X       = 8'd0,
    parameter logic [6:0] GROUND_Y      = 7'd80,
    parameter logic [7:0] X_MAX         = 8'(SCREEN_W - SPRITE_W),
    parameter int         JUMP_FRAMES   = 16,
    parameter logic [2:0] SPRITE_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR     = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic       left,
    input  logic       right,
    input  logic       jump,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y,
    output logic       airborne
);

    localparam int         CW        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [7:0] RISE_INIT = 8'(JUMP_FRAMES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] frame_cnt;
    logic          tick;
    logic          pending;
    logic [7:0]    rise_cnt, rise_nxt;
    logic [7:0]    pos_x_nxt;
    logic [6:0]    pos_y_nxt;
    logic          air_nxt;
    logic          start_pass;
    logic [2:0]    pass_colour;
    logic          pass_done;

    assign tick = (state != INIT) && (frame_cnt == CW'(FRAME_CYCLES - 1));

    always_comb begin
        state_nxt   = state;
        start_pass  = 1'b0;
        pass_colour = SPRITE_COLOUR;
        case (state)
            INIT: if (go) begin
                state_nxt  = DRAW;
                start_pass = 1'b1;
            end
            WAIT: if (tick || pending) begin
                state_nxt   = ERASE;
                start_pass  = 1'b1;
                pass_colour = BG_COLOUR;
            end
            ERASE:  if (pass_done) state_nxt = UPDATE;
            UPDATE: begin
                state_nxt  = DRAW;
                start_pass = 1'b1;
            end
            DRAW:   if (pass_done) state_nxt = WAIT;
            default: state_nxt = INIT;
        endcase
    end

    // The jump frame itself counts as the first rising frame, hence RISE_INIT = JUMP_FRAMES-1.
    always_comb begin
        pos_x_nxt = pos_x;
        pos_y_nxt = pos_y;
        air_nxt   = airborne;
        rise_nxt  = rise_cnt;
        if (state == INIT && go) begin
            pos_x_nxt = SPAWN_X;
            pos_y_nxt = GROUND_Y;
            air_nxt   = 1'b0;
            rise_nxt  = 8'd0;
        end else if (state == UPDATE) begin
            if (left && !right && pos_x != 8'd0)
                pos_x_nxt = pos_x - 8'd1;
            else if (right && !left && pos_x < X_MAX)
                pos_x_nxt = pos_x + 8'd1;
            if (!airborne && jump) begin
                air_nxt   = 1'b1;
                rise_nxt  = RISE_INIT;
                pos_y_nxt = pos_y - 7'd1;
            end else if (rise_cnt != 8'd0) begin
                rise_nxt  = rise_cnt - 8'd1;
                pos_y_nxt = pos_y - 7'd1;
            end else if (airborne) begin
                pos_y_nxt = pos_y + 7'd1;
                if (pos_y + 7'd1 == GROUND_Y)
                    air_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= INIT;
            frame_cnt <= '0;
            pending   <= 1'b0;
            busy      <= 1'b0;
            pos_x     <= SPAWN_X;
            pos_y     <= GROUND_Y;
            airborne  <= 1'b0;
            rise_cnt  <= 8'd0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == ERASE) || (state_nxt == UPDATE) || (state_nxt == DRAW);
            pos_x    <= pos_x_nxt;
            pos_y    <= pos_y_nxt;
            airborne <= air_nxt;
            rise_cnt <= rise_nxt;
            if (state == INIT || tick)
                frame_cnt <= '0;
            else
                frame_cnt <= frame_cnt + CW'(1);
            if (state == WAIT)
                pending <= 1'b0;
            else if (tick)
                pending <= 1'b1;
        end
    end

    // Base follows the next-state position so the draw after UPDATE uses the new coordinates.
    sprite_pixel_walker u_walker (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start_pass),
        .base_x     (pos_x_nxt),
        .base_y     (pos_y_nxt),
        .colour     (pass_colour),
        .x          (x_out),
        .y          (y_out),
        .pix_colour (colour_out),
        .plot       (plot),
        .done       (pass_done)
    );

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Directed bench for sprite_frame_sequencer: spawn draw, movement, saturation, jump arc,
// pending-tick collapse and mid-draw reset.
module tb_sprite_frame_sequencer;
    import mario_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, go, left, right, jump;
    logic [7:0] x_out, pos_x;
    logic [6:0] y_out, pos_y;
    logic [2:0] colour_out;
    logic       plot, busy, airborne;

    logic       resetn2, go2, z0;
    logic [7:0] x2, px2;
    logic [6:0] y2, py2;
    logic [2:0] c2;
    logic       plot2, busy2, air2;

    sprite_frame_sequencer #(.FRAME_CYCLES(64)) dut (
        .clk(clk), .resetn(resetn), .go(go), .left(left), .right(right), .jump(jump),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot), .busy(busy),
        .pos_x(pos_x), .pos_y(pos_y), .airborne(airborne)
    );

    sprite_frame_sequencer #(.FRAME_CYCLES(40)) dut2 (
        .clk(clk), .resetn(resetn2), .go(go2), .left(z0), .right(z0), .jump(z0),
        .x_out(x2), .y_out(y2), .colour_out(c2), .plot(plot2), .busy(busy2),
        .pos_x(px2), .pos_y(py2), .airborne(air2)
    );

    typedef struct {
        logic  l;
        logic  r;
        logic  j;
        int    ex;
        int    ey;
        int    eair;
        string nm;
    } fvec_t;

    fvec_t tab [0:8];
    int    tests = 0;
    int    fails = 0;
    int    prev_x, prev_y;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One full frame: erase at previous position, update, draw at expected new position.
    task automatic do_frame(input logic l, input logic r, input logic j,
                            input int ex, input int ey, input int eair, input string nm);
        int n, c, perr, k;
        left = l; right = r; jump = j;
        n = 0;
        do begin
            step();
            n++;
        end while (busy !== 1'b1 && n < 200);
        if (busy !== 1'b1) begin
            check({nm, "_start"}, 0, 1);
            return;
        end
        perr = 0;
        c = 0;
        while (busy === 1'b1 && c < 60) begin
            if (c < 16) begin
                if (plot !== 1'b1 || int'(x_out) != prev_x + c % 4 ||
                    int'(y_out) != prev_y + c / 4 || colour_out !== 3'd0) perr++;
            end else if (c == 16) begin
                if (plot !== 1'b0) perr++;
            end else begin
                k = c - 17;
                if (plot !== 1'b1 || int'(x_out) != ex + k % 4 ||
                    int'(y_out) != ey + k / 4 || colour_out !== 3'd4) perr++;
            end
            step();
            c++;
        end
        check({nm, "_len"}, c, 33);
        check({nm, "_pix"}, perr, 0);
        check({nm, "_pos_x"}, int'(pos_x), ex);
        check({nm, "_pos_y"}, int'(pos_y), ey);
        check({nm, "_air"}, int'(airborne), eair);
        prev_x = ex;
        prev_y = ey;
    endtask

    initial begin
        int perr, n, idx, ex, ey, ea;
        logic ep;
        logic [2:0] ec;

        tab[0] = '{1'b0, 1'b1, 1'b0, 1,   80, 0, "right1"};
        tab[1] = '{1'b0, 1'b1, 1'b0, 2,   80, 0, "right2"};
        tab[2] = '{1'b0, 1'b1, 1'b0, 3,   80, 0, "right3"};
        tab[3] = '{1'b0, 1'b1, 1'b0, 156, 80, 0, "right_sat"};
        tab[4] = '{1'b1, 1'b1, 1'b0, 156, 80, 0, "lr_hi"};
        tab[5] = '{1'b0, 1'b0, 1'b0, 156, 80, 0, "none_hi"};
        tab[6] = '{1'b1, 1'b0, 1'b0, 155, 80, 0, "left1"};
        tab[7] = '{1'b1, 1'b0, 1'b0, 0,   80, 0, "left_sat"};
        tab[8] = '{1'b1, 1'b1, 1'b0, 0,   80, 0, "lr_lo"};

        z0 = 1'b0;
        resetn2 = 1'b0; go2 = 1'b0;
        resetn = 1'b0; go = 1'b0; left = 1'b0; right = 1'b0; jump = 1'b0;
        repeat (3) step();
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_xyc", int'({x_out, y_out, colour_out}), 0);
        check("rst_pos_x", int'(pos_x), 0);
        check("rst_pos_y", int'(pos_y), 80);
        check("rst_air", int'(airborne), 0);

        // Spawn draw, then idle until the first tick
        resetn = 1'b1;
        step();
        go = 1'b1;
        step();
        go = 1'b0;
        perr = 0;
        for (int c = 0; c < 16; c++) begin
            if (plot !== 1'b1 || busy !== 1'b1 || int'(x_out) != c % 4 ||
                int'(y_out) != 80 + c / 4 || colour_out !== 3'd4) perr++;
            step();
        end
        check("spawn_pix", perr, 0);
        perr = 0;
        for (int c = 0; c < 48; c++) begin
            if (plot !== 1'b0 || busy !== 1'b0) perr++;
            if (c < 47) step();
        end
        check("spawn_idle", perr, 0);
        prev_x = 0;
        prev_y = 80;

        for (int i = 0; i < 9; i++) begin
            if (i == 3)
                for (int k = 4; k < 156; k++) do_frame(1'b0, 1'b1, 1'b0, k, 80, 0, "run_r");
            if (i == 7)
                for (int k = 154; k > 0; k--) do_frame(1'b1, 1'b0, 1'b0, k, 80, 0, "run_l");
            do_frame(tab[i].l, tab[i].r, tab[i].j, tab[i].ex, tab[i].ey, tab[i].eair, tab[i].nm);
        end

        // Jump arc: 16 frames rising to 64, 16 frames falling back to 80, mid-air jump ignored
        for (int i = 1; i <= 32; i++) begin
            ey = (i <= 16) ? 80 - i : 48 + i;
            ea = (i == 32) ? 0 : 1;
            do_frame(1'b0, 1'b0, (i == 1 || i == 8), 0, ey, ea, "jump");
        end
        do_frame(1'b0, 1'b0, 1'b0, 0, 80, 0, "landed");

        // Reset during draw pixel 7
        do_frame(1'b0, 1'b1, 1'b0, 1, 80, 0, "pre_rst");
        right = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (busy !== 1'b1 && n < 200);
        repeat (24) step();
        check("rst_mid_pix7_x", int'(x_out), 5);
        check("rst_mid_pix7_y", int'(y_out), 81);
        resetn = 1'b0;
        right = 1'b0;
        step();
        check("rst_mid_plot", int'(plot), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_state", int'(dut.state), int'(INIT));
        check("rst_mid_pos_x", int'(pos_x), 0);
        check("rst_mid_pos_y", int'(pos_y), 80);
        check("rst_mid_x_out", int'(x_out), 0);

        // Short frame, two forced ticks while drawing collapse into one extra pass
        repeat (2) step();
        resetn2 = 1'b1;
        step();
        go2 = 1'b1;
        step();
        go2 = 1'b0;
        perr = 0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 6 || k == 10) release dut2.tick;
            if (k == 10) check("pend_set", int'(dut2.pending), 1);
            if (k == 17) check("pend_clr", int'(dut2.pending), 0);
            if (k == 5 || k == 9) force dut2.tick = 1'b1;
            ep  = (k <= 15) || (k >= 17 && k <= 32) || (k >= 34);
            idx = (k < 16) ? k : (k < 33) ? k - 17 : k - 34;
            ec  = (k >= 17 && k <= 32) ? 3'd0 : 3'd4;
            ex  = idx % 4;
            ey  = 80 + idx / 4;
            if (plot2 !== ep) perr++;
            if (ep && (int'(x2) != ex || int'(y2) != ey || c2 !== ec)) perr++;
            if (plot2 === 1'b1) n++;
            step();
        end
        check("pend_trace", perr, 0);
        check("pend_plots", n, 48);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
